iob_bank: RTL

- Parametrised bank of WIDTH tristate I/O channels.
- Adds registered output/enable, a per-channel bus-turnaround guard, an optional open-drain mode, an input synchroniser and a per-channel glitch filter.
- Sits between core logic and device pins for bidirectional buses such as I2C, MDIO and parallel buses.
- Pad primitives are selected by ARCH.

---
 rtl/iob_bank_if.sv | 13 +
 rtl/iob_bank.sv | 135 +++++++++++++
 2 files changed

// File: rtl/iob_bank_if.sv
// Core-side signal group of an iob_bank: drive data/requests in, filtered
// pad values and applied drive enables out.
interface iob_bank_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] oe;

  modport master (output i, output t, input o, input oe);
  modport slave  (input i, input t, output o, output oe);
endinterface

// File: rtl/iob_bank.sv
// Bank of tristate I/O channels: registered drive with per-channel bus
// turnaround guard, optional open-drain, input synchroniser and glitch filter.
module iob_bank #(
  parameter string ARCH        = "GENERIC",
  parameter int    WIDTH       = 1,
  parameter int    OPEN_DRAIN  = 0,
  parameter int    SYNC_STAGES = 2,
  parameter int    FILTER_LEN  = 1,
  parameter int    TURNAROUND  = 0,
  parameter bit    RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  iob_bank_if.slave        bus,
  inout  wire  [WIDTH-1:0] pad
);
  localparam int CNT_W = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
  localparam int FC_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TURNAROUND);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);

  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] o_q, o_d;
  logic [FC_W-1:0]  fc_q [WIDTH];
  logic [FC_W-1:0]  fc_d [WIDTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] drv_en, drv_val;

  assign s = sync_q[SYNC_STAGES-1];

  // Release is immediate; re-drive waits until the idle counter has drained.
  always_comb begin
    dq_d = bus.i;
    oe_d = oe_q;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (oe_q[k]) begin
        if (!bus.t[k]) begin
          oe_d[k]  = 1'b0;
          cnt_d[k] = TA_LOAD;
        end
      end else if (cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end else if (bus.t[k]) begin
        oe_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sync_d[0] = pad;
    for (int st = 1; st < SYNC_STAGES; st++) begin
      sync_d[st] = sync_q[st-1];
    end
  end

  // o only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    o_d = o_q;
    for (int k = 0; k < WIDTH; k++) begin
      fc_d[k] = fc_q[k];
      if (s[k] == o_q[k]) begin
        fc_d[k] = '0;
      end else if (fc_q[k] == FC_LAST) begin
        o_d[k]  = s[k];
        fc_d[k] = '0;
      end else begin
        fc_d[k] = fc_q[k] + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_q <= '0;
      oe_q <= '0;
      o_q  <= {WIDTH{RESET_VAL}};
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= '0;
        fc_q[k]  <= '0;
      end
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= {WIDTH{RESET_VAL}};
      end
    end else begin
      dq_q <= dq_d;
      oe_q <= oe_d;
      o_q  <= o_d;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
        fc_q[k]  <= fc_d[k];
      end
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_d[st];
      end
    end
  end

  assign bus.o  = o_q;
  assign bus.oe = oe_q;

  always_comb begin
    if (OPEN_DRAIN != 0) begin
      drv_en  = oe_q & ~dq_q;
      drv_val = '0;
    end else begin
      drv_en  = oe_q;
      drv_val = dq_q;
    end
  end

  generate
    if (ARCH == "GENERIC") begin : g_generic
      for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
      end
    end else if (ARCH == "XIL_SPARTAN6" || ARCH == "XIL_VIRTEX6" ||
                 ARCH == "XIL_7SERIES") begin : g_xil
      // IOBUF pin semantics: T high releases the pad, I is the driven value.
      logic [WIDTH-1:0] iob_t, iob_i;
      assign iob_t = ~drv_en;
      assign iob_i = drv_val;
      for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        assign pad[k] = iob_t[k] ? 1'bz : iob_i[k];
      end
    end else begin : g_bad_arch
      $fatal(1, "%m: unsupported ARCH \"%s\"", ARCH);
    end
  endgenerate
endmodule
